client_traffic_ctrl: RTL and testbench

Parametrised next-generation bus-arbiter client controller. It generates bursts of write/read requests toward the arbiter, holds `rq` until `ack` per beat, and supports four direction modes. Pseudo-random inter-burst gaps come from an internal LFSR; an ack timeout triggers a burst retry. It sits between the arbiter port and the client's address, data and LFSR resources.

---
 rtl/client_traffic_pkg.sv | 33 +++
 rtl/client_traffic_ctrl_lfsr.sv | 27 ++
 rtl/client_traffic_ctrl.sv | 157 +++++++++++++++
 tb/tb_client_traffic_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/client_traffic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// client_traffic_pkg : shared encodings for the arbiter client controller
// Revision: 1.0
// ---------------------------------------------------------------------------
package client_traffic_pkg;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] GAP  = 2'b01;
   localparam logic [1:0] REQ  = 2'b10;

   localparam logic [1:0] MODE_WR  = 2'b00;
   localparam logic [1:0] MODE_RD  = 2'b01;
   localparam logic [1:0] MODE_ALT = 2'b10;
   localparam logic [1:0] MODE_RND = 2'b11;

   localparam logic DIR_WR = 1'b0;
   localparam logic DIR_RD = 1'b1;

   function automatic logic pick_dir(input logic [1:0] mode, input logic alt_phase,
                                     input logic [15:0] lfsr);
      logic dir;
      case (mode)
         MODE_WR:  dir = DIR_WR;
         MODE_RD:  dir = DIR_RD;
         MODE_ALT: dir = alt_phase;
         default:  dir = lfsr[15];
      endcase
      return dir;
   endfunction

endpackage
`default_nettype wire

// File: rtl/client_traffic_ctrl_lfsr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// client_lfsr : 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running
// Revision: 1.0
// ---------------------------------------------------------------------------
module client_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   logic [15:0] q_q;
   logic [15:0] q_d;

   assign q_d = {q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5], q_q[15:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= SEED;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/client_traffic_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// client_traffic_ctrl : burst request generator for a bus-arbiter client port
// Revision: 1.0
// ---------------------------------------------------------------------------
module client_traffic_ctrl
   import client_traffic_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned GAP_BITS   = 3,
   parameter int unsigned TIMEOUT    = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic                  ack,
   output logic                  rq,
   output logic                  wr_ni,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  burst_done,
   output logic                  timeout_err
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_LEN - 1);
   localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] BASE_STEP = ADDR_WIDTH'(BURST_LEN);

   logic [15:0] lfsr;

   logic [1:0]            state_q, state_d;
   logic [GAP_BITS-1:0]   gap_q, gap_d;
   logic                  dir_q, dir_d;
   logic                  alt_q, alt_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic                  done_q, done_d;
   logic                  tmo_q, tmo_d;

   client_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr)
   );

   always_comb begin
      state_d  = state_q;
      gap_d    = gap_q;
      dir_d    = dir_q;
      alt_d    = alt_q;
      base_d   = base_q;
      beat_d   = beat_q;
      data_d   = data_q;
      shadow_d = shadow_q;
      wait_d   = wait_q;
      done_d   = 1'b0;
      tmo_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d  = GAP;
               gap_d    = lfsr[GAP_BITS-1:0];
               dir_d    = pick_dir(mode, alt_q, lfsr);
               shadow_d = data_q;
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = REQ;
            else             gap_d   = gap_q - 1'b1;
         end
         REQ: begin
            if (ack) begin
               wait_d = '0;
               if (dir_q == DIR_WR) data_d = data_q + 1'b1;
               if (beat_q == BEAT_LAST) begin
                  done_d = 1'b1;
                  beat_d = '0;
                  // Alternate mode reads back the block it just wrote before moving on.
                  if (mode == MODE_ALT && dir_q == DIR_WR) begin
                     alt_d = DIR_RD;
                  end else begin
                     base_d = base_q + BASE_STEP;
                     if (mode == MODE_ALT) alt_d = DIR_WR;
                  end
                  if (enable) begin
                     state_d  = GAP;
                     gap_d    = lfsr[GAP_BITS-1:0];
                     dir_d    = pick_dir(mode, alt_d, lfsr);
                     shadow_d = data_d;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
               // Retry keeps base and direction; write data rewinds to the burst start.
               tmo_d   = 1'b1;
               beat_d  = '0;
               wait_d  = '0;
               data_d  = shadow_q;
               gap_d   = lfsr[GAP_BITS-1:0];
               state_d = enable ? GAP : IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         gap_q    <= '0;
         dir_q    <= DIR_WR;
         alt_q    <= DIR_WR;
         base_q   <= '0;
         beat_q   <= '0;
         data_q   <= '0;
         shadow_q <= '0;
         wait_q   <= '0;
         done_q   <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         dir_q    <= dir_d;
         alt_q    <= alt_d;
         base_q   <= base_d;
         beat_q   <= beat_d;
         data_q   <= data_d;
         shadow_q <= shadow_d;
         wait_q   <= wait_d;
         done_q   <= done_d;
         tmo_q    <= tmo_d;
      end
   end

   assign rq          = (state_q == REQ);
   assign wr_ni       = dir_q;
   assign addr        = base_q + ADDR_WIDTH'(beat_q);
   assign wdata       = data_q;
   assign burst_done  = done_q;
   assign timeout_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_client_traffic_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_client_traffic_ctrl : vector table + beat scoreboard for client_traffic_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_client_traffic_ctrl;
   import client_traffic_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       ack;
   logic [1:0] mode;
   logic       rq, wr_ni, burst_done, timeout_err;
   logic [7:0] addr, wdata;
   logic       rq3, wr_ni3, done3, tmo3;
   logic [2:0] addr3;
   logic [7:0] wdata3;

   always #5 clk = ~clk;

   client_traffic_ctrl #(
      .ADDR_WIDTH(8), .DATA_WIDTH(8), .BURST_LEN(4), .GAP_BITS(3),
      .TIMEOUT(8), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .ack(ack),
      .rq(rq), .wr_ni(wr_ni), .addr(addr), .wdata(wdata),
      .burst_done(burst_done), .timeout_err(timeout_err)
   );

   // Narrow-address twin sees identical stimulus; only its address width differs.
   client_traffic_ctrl #(
      .ADDR_WIDTH(3), .DATA_WIDTH(8), .BURST_LEN(4), .GAP_BITS(3),
      .TIMEOUT(8), .LFSR_SEED(16'hACE1)
   ) dut3 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .ack(ack),
      .rq(rq3), .wr_ni(wr_ni3), .addr(addr3), .wdata(wdata3),
      .burst_done(done3), .timeout_err(tmo3)
   );

   typedef struct {
      logic [7:0] addr;
      logic       wr_ni;
      logic [7:0] wdata;
      logic [2:0] addr3;
   } exp_t;

   typedef struct {
      logic       rst_first;
      logic [1:0] mode;
      int         delay;
      exp_t       exp;
      logic       done;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input int a, input logic w, input int d);
      exp_t e;
      e.addr  = 8'(a);
      e.wr_ni = w;
      e.wdata = 8'(d);
      e.addr3 = 3'(a);
      return e;
   endfunction

   task automatic add_vec(input logic rf, input logic [1:0] m, input int dly,
                          input int a, input logic w, input int d, input logic dn);
      vec_t v;
      v.rst_first = rf;
      v.mode      = m;
      v.delay     = dly;
      v.exp       = mk(a, w, d);
      v.done      = dn;
      vecs.push_back(v);
   endtask

   // Beat monitor: each accepted beat pops one expected record.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && rq === 1'b1 && ack === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected_beat: got beat at addr %0h expected none", addr);
         end else begin
            e = sb.pop_front();
            check("beat_addr",  {24'd0, addr},  {24'd0, e.addr});
            check("beat_wr_ni", {31'd0, wr_ni}, {31'd0, e.wr_ni});
            check("beat_wdata", {24'd0, wdata}, {24'd0, e.wdata});
            check("beat_addr3", {29'd0, addr3}, {29'd0, e.addr3});
         end
      end
   end

   task automatic drive_beat(input int delay, output logic done_seen);
      bit found = 1'b0;
      done_seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (rq === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      if (!found) begin
         n_checks++;
         n_errors++;
         $display("FAIL rq_wait: got rq=0 expected rq=1 within 64 cycles");
         return;
      end
      repeat (delay) tick();
      ack = 1'b1;
      tick();
      done_seen = burst_done;
      ack = 1'b0;
   endtask

   task automatic do_reset();
      check("sb_empty", sb.size(), 0);
      sb.delete();
      rst = 1'b1; enable = 1'b0; ack = 1'b0; mode = MODE_WR;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      logic d;
      bit   seen;
      rst = 1'b1; enable = 1'b0; ack = 1'b0; mode = MODE_WR;
      tick();
      check("rst_rq",    {31'd0, rq},          0);
      check("rst_wr_ni", {31'd0, wr_ni},       0);
      check("rst_addr",  {24'd0, addr},        0);
      check("rst_wdata", {24'd0, wdata},       0);
      check("rst_done",  {31'd0, burst_done},  0);
      check("rst_tmo",   {31'd0, timeout_err}, 0);
      check("rst_lfsr",  {16'd0, dut.u_lfsr.q}, 32'hACE1);
      rst = 1'b0;
      tick();
      check("lfsr_step", {16'd0, dut.u_lfsr.q}, 32'h5670);

      // Write-only with sparse ack, then wrap of the 3-bit address: 12 beats.
      for (int i = 0; i < 12; i++)
         add_vec(i == 0, MODE_WR, (i < 8) ? 2 : 0, i, DIR_WR, i, (i % 4) == 3);
      // Alternate: W 0..3, R 0..3 (data held at 4), W 4..7.
      for (int i = 0; i < 4; i++) add_vec(i == 0, MODE_ALT, 0, i,     DIR_WR, i,     i == 3);
      for (int i = 0; i < 4; i++) add_vec(1'b0,   MODE_ALT, 0, i,     DIR_RD, 4,     i == 3);
      for (int i = 0; i < 4; i++) add_vec(1'b0,   MODE_ALT, 0, 4 + i, DIR_WR, 4 + i, i == 3);

      foreach (vecs[i]) begin
         if (vecs[i].rst_first) do_reset();
         mode   = vecs[i].mode;
         enable = 1'b1;
         sb.push_back(vecs[i].exp);
         drive_beat(vecs[i].delay, d);
         check($sformatf("vec%0d_burst_done", i), {31'd0, d}, {31'd0, vecs[i].done});
      end

      // Timeout: one beat, then starve ack; retry rewinds address and data.
      do_reset();
      mode = MODE_WR; enable = 1'b1;
      sb.push_back(mk(0, DIR_WR, 0));
      drive_beat(0, d);
      repeat (7) tick();
      check("tmo_rq_before",  {31'd0, rq},          1);
      check("tmo_err_before", {31'd0, timeout_err}, 0);
      tick();
      check("tmo_err_pulse",  {31'd0, timeout_err}, 1);
      check("tmo_rq_drop",    {31'd0, rq},          0);
      check("tmo_rewind",     {24'd0, wdata},       0);
      tick();
      check("tmo_err_clear",  {31'd0, timeout_err}, 0);
      sb.push_back(mk(0, DIR_WR, 0));
      drive_beat(7, d);
      check("tmo_ack_wins",   {31'd0, timeout_err}, 0);
      check("tmo_ack_rq",     {31'd0, rq},          1);
      tick();
      check("tmo_ack_nopulse", {31'd0, timeout_err}, 0);
      for (int i = 1; i < 4; i++) begin
         sb.push_back(mk(i, DIR_WR, i));
         drive_beat(0, d);
      end
      check("tmo_retry_done", {31'd0, d}, 1);

      // Enable dropped after the second ack: burst still completes, then idle.
      do_reset();
      mode = MODE_WR; enable = 1'b1;
      for (int i = 0; i < 4; i++) sb.push_back(mk(i, DIR_WR, i));
      drive_beat(1, d);
      drive_beat(1, d);
      enable = 1'b0;
      drive_beat(1, d);
      drive_beat(1, d);
      check("en_drop_done", {31'd0, d}, 1);
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (rq !== 1'b0) seen = 1'b1;
      end
      check("en_drop_rq_low", {31'd0, seen},     0);
      check("en_drop_idle",   {30'd0, dut.state_q}, {30'd0, IDLE});

      // Asynchronous reset while a request is outstanding.
      do_reset();
      mode = MODE_WR; enable = 1'b1;
      sb.push_back(mk(0, DIR_WR, 0));
      drive_beat(0, d);
      check("arst_pre_rq",   {31'd0, rq},    1);
      check("arst_pre_addr", {24'd0, addr},  1);
      rst = 1'b1;
      #1;
      check("arst_rq",    {31'd0, rq},          0);
      check("arst_addr",  {24'd0, addr},        0);
      check("arst_wdata", {24'd0, wdata},       0);
      check("arst_wr_ni", {31'd0, wr_ni},       0);
      check("arst_done",  {31'd0, burst_done},  0);
      check("arst_tmo",   {31'd0, timeout_err}, 0);
      check("arst_lfsr",  {16'd0, dut.u_lfsr.q}, 32'hACE1);
      tick();
      rst = 1'b0;
      tick();
      check("sb_empty_end", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
